// File: rtl/fsm_key_sender.sv
// Plays a CODE_LEN-bit code as b0/b1 press pulses into a combination lock, then waits for unlock feedback.
// Registered outputs; press pulses appear the cycle after PRESS, done is high while in FIN; start ignored while busy.
module fsm_key_sender #(
    parameter int CODE_LEN    = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int WAIT_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset_in,
    input  logic                start_in,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                abort_in,
    input  logic                unlock_in,
    output logic                b0_out,
    output logic                b1_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2:0]          hex_display
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRESS = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [2:0] LP_LEN       = 3'(CODE_LEN);
    localparam logic [3:0] LP_GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_CYCLES - 1);

    logic [2:0]          r_state, w_state;
    logic [CODE_LEN-1:0] r_shift, w_shift;
    logic [2:0]          r_cnt,   w_cnt;
    logic [3:0]          r_gap,   w_gap;
    logic [7:0]          r_wait,  w_wait;
    logic                r_b0,    w_b0;
    logic                r_b1,    w_b1;
    logic                r_busy,  w_busy;
    logic                r_done,  w_done;
    logic                r_pass,  w_pass;

    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
        w_wait  = r_wait;
        w_b0    = 1'b0;
        w_b1    = 1'b0;
        w_done  = 1'b0;
        w_pass  = r_pass;
        case (r_state)
            S_IDLE: begin
                // abort wins over a simultaneous start
                if (start_in && !abort_in) begin
                    w_shift = code_in;
                    w_cnt   = 3'd0;
                    w_gap   = 4'd0;
                    w_wait  = 8'd0;
                    w_state = S_PRESS;
                end
            end
            S_PRESS: begin
                if (abort_in) begin
                    w_state = S_IDLE;
                end else begin
                    w_b1    = r_shift[CODE_LEN-1];
                    w_b0    = ~r_shift[CODE_LEN-1];
                    w_shift = r_shift << 1;
                    if (r_cnt < LP_LEN) begin
                        w_cnt = r_cnt + 3'd1;
                    end
                    w_gap   = 4'd0;
                    w_state = S_GAP;
                end
            end
            S_GAP: begin
                if (abort_in) begin
                    w_state = S_IDLE;
                end else if (r_gap == LP_GAP_LAST) begin
                    w_gap   = 4'd0;
                    w_wait  = 8'd0;
                    w_state = (r_cnt < LP_LEN) ? S_PRESS : S_WAIT;
                end else begin
                    w_gap = r_gap + 4'd1;
                end
            end
            S_WAIT: begin
                // unlock in the final wait cycle still counts as a pass
                if (abort_in) begin
                    w_state = S_IDLE;
                end else if (unlock_in) begin
                    w_pass  = 1'b1;
                    w_done  = 1'b1;
                    w_state = S_FIN;
                end else if (r_wait == LP_WAIT_LAST) begin
                    w_pass  = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_FIN;
                end else begin
                    w_wait = r_wait + 8'd1;
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= 3'd0;
            r_gap   <= 4'd0;
            r_wait  <= 8'd0;
            r_b0    <= 1'b0;
            r_b1    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            r_wait  <= w_wait;
            r_b0    <= w_b0;
            r_b1    <= w_b1;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
        end
    end

    assign b0_out      = r_b0;
    assign b1_out      = r_b1;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign hex_display = r_cnt;

endmodule

// File: doc/fsm_key_sender.md
FSM_KEY_SENDER -- requirements
Module: fsm_key_sender

Interface
REQ-001 Parameter CODE_LEN, default 4: number of button presses per sequence; legal range 1..7.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles after each press, both buttons low; legal range 1..15.
REQ-003 Parameter WAIT_CYCLES, default 8: cycles to wait for unlock feedback after the last gap; legal range 1..255.
REQ-004 clk  input  1  single clock; all flops on its rising edge.
REQ-005 reset_in  input  1  asynchronous, active-high reset.
REQ-006 start_in  input  1  request to play code_in; sampled only in IDLE.
REQ-007 code_in  input  CODE_LEN  code to play; bit CODE_LEN-1 is sent first; 0 = b0 press, 1 = b1 press.
REQ-008 abort_in  input  1  cancels an in-progress sequence.
REQ-009 unlock_in  input  1  lock's unlock output, fed back.
REQ-010 b0_out  output  1  one-cycle press pulse for button 0.
REQ-011 b1_out  output  1  one-cycle press pulse for button 1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 pass  output  1  result of the last completed sequence; 1 = unlock seen.
REQ-015 hex_display  output  3  number of presses sent so far in the current or last sequence.

Function
REQ-016 States: IDLE, PRESS, GAP, WAIT, FIN; all outputs registered.
REQ-017 IDLE with start_in=1: latch code_in into the shift register, clear the press count and hex_display, then go to PRESS on the next edge.
REQ-018 IDLE with start_in=0: remain in IDLE; b0_out, b1_out and done are low.
REQ-019 PRESS, one cycle: drive b1_out=1 if the current MSB is 1, else b0_out=1; never both; shift left; increment the press count and hex_display; go to GAP.
REQ-020 GAP: both buttons low for exactly GAP_CYCLES cycles.
REQ-021 At the end of GAP: go to PRESS if presses sent < CODE_LEN, else go to WAIT.
REQ-022 Press pulses are therefore separated by exactly GAP_CYCLES low cycles; first press occurs 1 cycle after start is accepted.
REQ-023 WAIT: count up to WAIT_CYCLES cycles.
REQ-024 WAIT, unlock_in=1 in any cycle: set pass=1 and go to FIN immediately.
REQ-025 WAIT timeout (unlock_in never seen): set pass=0 and go to FIN.
REQ-026 unlock_in is ignored outside WAIT.
REQ-027 FIN, one cycle: done=1, then return to IDLE.
REQ-028 pass holds its value until the next done pulse or reset.
REQ-029 start_in while busy=1 is ignored; it is not queued.
REQ-030 abort_in=1 in PRESS, GAP or WAIT: go to IDLE at the next edge; no press is issued that cycle; done is not pulsed; pass is unchanged; hex_display holds the count reached.
REQ-031 abort_in in IDLE or FIN has no effect; start_in and abort_in both high in IDLE: abort has priority and start is not accepted.
REQ-032 Counters are sized to their parameter maxima; the press count saturates at CODE_LEN and never wraps.

Reset
REQ-033 reset_in=1 forces, asynchronously: state IDLE, b0_out=0, b1_out=0, busy=0, done=0, pass=0, hex_display=0, all counters and the shift register 0.
REQ-034 Reset asserted mid-sequence takes effect without waiting for a clock edge; after release, the block waits for a new start_in.
REQ-035 First start_in accepted on the first rising edge after reset_in deasserts.

Verification
REQ-036 Defaults, code_in=4'b0110, start pulse, unlock_in tied 0: press pattern is b0, b1, b1, b0, each separated by 2 low cycles; hex_display steps 1..4; done pulses 8 cycles after the last gap ends; pass=0.
REQ-037 Same as REQ-036, but unlock_in=1 for one cycle at WAIT cycle 3: done pulses on the next cycle; pass=1.
REQ-038 abort_in asserted during the GAP after the second press: no further presses; busy=0 next cycle; no done pulse; hex_display=2; pass unchanged.
REQ-039 start_in held high for the whole sequence: exactly one sequence of 4 presses, then a new sequence starts 1 cycle after done.
REQ-040 reset_in pulsed between clock edges during PRESS: b0_out, b1_out and busy go low immediately; all outputs read 0.
REQ-041 CODE_LEN=1, GAP_CYCLES=1, code_in=1'b1: one b1 press; WAIT entered after 1 gap cycle; no b0 activity at any time.
